// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 2-flop rx synchronizer, 16x oversampled framing FSM, and a valid/ready output register.
// Optional macro UART_RX_RTS_EN adds flow_control input and registered rts_n output.
module uart_rx_deser #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     divider,
   input  logic                 rx_en,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 flush_rx,
   input  logic                 rx,
`ifdef UART_RX_RTS_EN
   input  logic                 flow_control,
   output logic                 rts_n,
`endif
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_parity_err,
   output logic                 out_framing_err,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun_error,
   output logic                 busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_q, state_d;
   logic                 rx_meta_q, rx_meta_d;
   logic                 rx_s_q, rx_s_d;
   logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_err_q, par_err_d;
   logic [DATA_BITS-1:0] out_data_q, out_data_d;
   logic                 out_perr_q, out_perr_d;
   logic                 out_ferr_q, out_ferr_d;
   logic                 out_valid_q, out_valid_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_RX_RTS_EN
   logic                 rts_n_q, rts_n_d;
`endif

   logic tick;
   logic samp_last;
   logic complete;

   always_comb begin
      state_d     = state_q;
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
      tick_cnt_d  = tick_cnt_q;
      div_d       = div_q;
      samp_cnt_d  = samp_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      par_err_d   = par_err_q;
      out_data_d  = out_data_q;
      out_perr_d  = out_perr_q;
      out_ferr_d  = out_ferr_q;
      out_valid_d = out_valid_q;
      overrun_d   = 1'b0;
      complete    = 1'b0;

      // The divider is captured only while idle or at a wrap, so a change never truncates a tick period.
      tick = (state_q != IDLE) && (tick_cnt_q == div_q);
      if (state_q == IDLE || tick) begin
         tick_cnt_d = '0;
         div_d      = divider;
      end else begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end

      samp_last = tick && (samp_cnt_q == ((state_q == START) ? HALF_LAST : FULL_LAST));
      if (tick) samp_cnt_d = samp_last ? '0 : samp_cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (rx_en && !rx_s_q) begin
               state_d    = START;
               samp_cnt_d = '0;
               par_err_d  = 1'b0;
            end
         end
         START: begin
            if (samp_last) begin
               state_d   = rx_s_q ? IDLE : DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (samp_last) begin
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == BITS_LAST) state_d = parity_en ? PARITY : STOP;
               else                        bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         PARITY: begin
            if (samp_last) begin
               par_err_d = (^shift_q) ^ rx_s_q ^ parity_odd;
               state_d   = STOP;
            end
         end
         STOP: begin
            if (samp_last) begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!rx_en) begin
         state_d  = IDLE;
         complete = 1'b0;
      end

      // A word completing while the previous one is still unaccepted is dropped, never overwritten.
      if (flush_rx) begin
         state_d     = IDLE;
         tick_cnt_d  = '0;
         out_data_d  = '0;
         out_perr_d  = 1'b0;
         out_ferr_d  = 1'b0;
         out_valid_d = 1'b0;
      end else if (complete) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = shift_q;
            out_perr_d  = parity_en & par_err_q;
            out_ferr_d  = ~rx_s_q;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

`ifdef UART_RX_RTS_EN
      rts_n_d = flow_control & out_valid_q;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         tick_cnt_q  <= '0;
         div_q       <= '0;
         samp_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         par_err_q   <= 1'b0;
         out_data_q  <= '0;
         out_perr_q  <= 1'b0;
         out_ferr_q  <= 1'b0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_RTS_EN
         rts_n_q     <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         tick_cnt_q  <= tick_cnt_d;
         div_q       <= div_d;
         samp_cnt_q  <= samp_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         par_err_q   <= par_err_d;
         out_data_q  <= out_data_d;
         out_perr_q  <= out_perr_d;
         out_ferr_q  <= out_ferr_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_RTS_EN
         rts_n_q     <= rts_n_d;
`endif
      end
   end

   assign out_data        = out_data_q;
   assign out_parity_err  = out_perr_q;
   assign out_framing_err = out_ferr_q;
   assign out_valid       = out_valid_q;
   assign overrun_error   = overrun_q;
   assign busy            = (state_q != IDLE);
`ifdef UART_RX_RTS_EN
   assign rts_n           = rts_n_q;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Testbench for uart_rx_deser: directed serial frames, scoreboard queue of expected words and a separate output monitor.
module tb_uart_rx_deser;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] divider;
   logic        rx_en, parity_en, parity_odd, flush_rx, rx, out_ready;
   logic [7:0]  out_data;
   logic        out_parity_err, out_framing_err, out_valid, overrun_error, busy;
`ifdef UART_RX_RTS_EN
   logic        rts_n;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   ovr_cnt = 0;
   int   first_valid_cycle = -1;
   int   start_cycle = 0;

   uart_rx_deser #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .divider(divider),
      .rx_en(rx_en),
      .parity_en(parity_en),
      .parity_odd(parity_odd),
      .flush_rx(flush_rx),
      .rx(rx),
`ifdef UART_RX_RTS_EN
      .flow_control(1'b0),
      .rts_n(rts_n),
`endif
      .out_data(out_data),
      .out_parity_err(out_parity_err),
      .out_framing_err(out_framing_err),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .overrun_error(overrun_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic expectWord(input logic [7:0] d, input logic p, input logic f);
      exp_t e;
      e.data = d;
      e.perr = p;
      e.ferr = f;
      exp_q.push_back(e);
   endtask

   task automatic driveBit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   // One serial frame, LSB first; caller is aligned to a falling clock edge.
   task automatic applyStimulus(input logic [7:0] d, input logic use_par, input logic pbit,
                                input logic stop_bit, input int bit_clks);
      logic [7:0] b;
      b = d;
      start_cycle = cycle;
      driveBit(1'b0, bit_clks);
      for (int i = 0; i < 8; i++) driveBit(b[i], bit_clks);
      if (use_par) driveBit(pbit, bit_clks);
      driveBit(stop_bit, bit_clks);
      rx = 1'b1;
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
   endtask

   // Monitor: every accepted word is popped from the scoreboard and compared.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (overrun_error) ovr_cnt++;
            if (out_valid && out_ready) begin
               if (first_valid_cycle < 0) first_valid_cycle = cycle;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_word actual=%0h required=none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("out_data", {24'd0, out_data}, {24'd0, e.data});
                  checkOutput("out_parity_err", {31'd0, out_parity_err}, {31'd0, e.perr});
                  checkOutput("out_framing_err", {31'd0, out_framing_err}, {31'd0, e.ferr});
               end
            end
         end
      end
   end

   initial begin
      int lat;
      int ovr_before;
      rst = 1'b1; rx = 1'b1; rx_en = 1'b1; divider = 16'd0;
      parity_en = 1'b0; parity_odd = 1'b0; flush_rx = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_valid", {31'd0, out_valid}, 0);
      checkOutput("reset_data", {24'd0, out_data}, 0);
      checkOutput("reset_busy", {31'd0, busy}, 0);
      checkOutput("reset_overrun", {31'd0, overrun_error}, 0);
      checkOutput("reset_flags", {30'd0, out_parity_err, out_framing_err}, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Plain 8N1 frame with latency measurement.
      expectWord(8'hA5, 1'b0, 1'b0);
      first_valid_cycle = -1;
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 16);
      drain(200);
      lat = first_valid_cycle - start_cycle;
      checkOutput("latency_window", {31'd0, (lat >= 148 && lat <= 160)}, 1);
      repeat (10) @(negedge clk);

      // Even parity, wrong then right parity bit; odd parity correct.
      parity_en = 1'b1;
      expectWord(8'h03, 1'b1, 1'b0);
      applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 16);
      repeat (8) @(negedge clk);
      expectWord(8'h03, 1'b0, 1'b0);
      applyStimulus(8'h03, 1'b1, 1'b0, 1'b1, 16);
      repeat (8) @(negedge clk);
      parity_odd = 1'b1;
      expectWord(8'h07, 1'b0, 1'b0);
      applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, 16);
      drain(100);
      parity_en = 1'b0; parity_odd = 1'b0;
      repeat (10) @(negedge clk);

      // Framing error; the lingering low re-arms a start that is rejected.
      expectWord(8'h5A, 1'b0, 1'b1);
      applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0, 16);
      repeat (40) @(negedge clk);
      checkOutput("break_recovered_busy", {31'd0, busy}, 0);
      expectWord(8'h11, 1'b0, 1'b0);
      applyStimulus(8'h11, 1'b0, 1'b0, 1'b1, 16);
      drain(100);
      repeat (10) @(negedge clk);

      // Slower baud: divider=1 gives 32 clocks per bit.
      divider = 16'd1;
      expectWord(8'h96, 1'b0, 1'b0);
      applyStimulus(8'h96, 1'b0, 1'b0, 1'b1, 32);
      drain(200);
      divider = 16'd0;
      repeat (10) @(negedge clk);

      // Overrun: second word dropped while first is held.
      out_ready = 1'b0;
      ovr_before = ovr_cnt;
      expectWord(8'h01, 1'b0, 1'b0);
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 16);
      repeat (4) @(negedge clk);
      applyStimulus(8'h02, 1'b0, 1'b0, 1'b1, 16);
      repeat (20) @(negedge clk);
      checkOutput("overrun_pulses", ovr_cnt - ovr_before, 1);
      checkOutput("held_data", {24'd0, out_data}, 32'h01);
      checkOutput("held_valid", {31'd0, out_valid}, 1);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("valid_cleared", {31'd0, out_valid}, 0);
      checkOutput("overrun_queue", exp_q.size(), 0);

      // Short glitch shorter than half a bit.
      driveBit(1'b0, 4);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("glitch_busy_seen", {31'd0, busy}, 1);
      repeat (20) @(negedge clk);
      checkOutput("glitch_busy_done", {31'd0, busy}, 0);
      checkOutput("glitch_no_valid", {31'd0, out_valid}, 0);

      // Reset mid-DATA.
      fork
         applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 16);
         begin
            repeat (60) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      checkOutput("rst_mid_data", {24'd0, out_data}, 0);
      checkOutput("rst_mid_busy", {31'd0, busy}, 0);
      expectWord(8'h3C, 1'b0, 1'b0);
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 16);
      drain(100);
      repeat (10) @(negedge clk);

      // Flush mid-DATA with a word held unaccepted.
      out_ready = 1'b0;
      applyStimulus(8'h77, 1'b0, 1'b0, 1'b1, 16);
      repeat (4) @(negedge clk);
      checkOutput("pre_flush_valid", {31'd0, out_valid}, 1);
      ovr_before = ovr_cnt;
      fork
         applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 16);
         begin
            repeat (60) @(negedge clk);
            flush_rx = 1'b1;
            @(negedge clk);
            flush_rx = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      checkOutput("flush_valid", {31'd0, out_valid}, 0);
      checkOutput("flush_data", {24'd0, out_data}, 0);
      checkOutput("flush_busy", {31'd0, busy}, 0);
      checkOutput("flush_no_overrun", ovr_cnt - ovr_before, 0);
      out_ready = 1'b1;
      expectWord(8'h3C, 1'b0, 1'b0);
      applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 16);
      drain(100);
      repeat (10) @(negedge clk);
      checkOutput("final_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Receive-side serial front end of the UART.
- Samples the RX pin against a 16x oversampling tick derived from the DIVIDER register. Detects start bits, reassembles data LSB-first, checks parity and stop bit.
- Presents each received word with error flags on a valid/ready interface to the downstream RX FIFO.
- Supplies the parity_error, framing_error, overrun_error and data_ready sources for the RX IRQ flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- OVERSAMPLE, 16, oversampling ticks per bit; must be even, at least 4.
- DIV_W, 16, width of the baud divider input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- divider  in  DIV_W  oversample tick period minus one, in clk cycles
- rx_en  in  1  receiver enable; low when the mode/master config disables the RX line
- parity_en  in  1  a parity bit follows the data bits
- parity_odd  in  1  1 = odd parity, 0 = even parity
- flush_rx  in  1  synchronous flush of receiver state and output register
- rx  in  1  asynchronous serial input, idle high
- out_data  out  DATA_BITS  received word
- out_parity_err  out  1  parity mismatch for out_data
- out_framing_err  out  1  stop bit sampled low for out_data
- out_valid  out  1  out_data/flags valid
- out_ready  in  1  consumer accepts the word when high with out_valid
- overrun_error  out  1  one-cycle pulse: a completed word was dropped
- busy  out  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0; rx synchronizer flops reset to 1; state IDLE; tick counter 0.
- Synchronizer: rx passes through a 2-flop synchronizer (rx_s). Its 2-cycle latency is the same for all edges, so it does not affect bit timing.
- Tick generator:
  - Counter runs 0..divider and asserts tick when it equals divider, then wraps to 0.
  - divider=0 gives tick every cycle.
  - Counter is held at 0 in IDLE and restarts on the start edge, so the first tick comes divider+1 cycles after the edge.
  - A divider change takes effect at the next wrap.
- State machine (states IDLE, START, DATA, PARITY, STOP):
  - IDLE: on rx_s=0 with rx_en=1, go to START and clear the sample counter.
  - START: count OVERSAMPLE/2 ticks, then sample rx_s. If 0, go to DATA with bit index 0. If 1, treat as a glitch: return to IDLE with no output and no flag.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift[bit index] (LSB first). After DATA_BITS samples, go to PARITY if parity_en, else STOP.
  - PARITY: sample after OVERSAMPLE ticks. Error when the XOR of the data bits XOR the parity bit XOR parity_odd is 1.
  - STOP: sample after OVERSAMPLE ticks; framing error when the sample is 0. Complete the word and return to IDLE in the same cycle.
- Back-to-back frames: IDLE re-arms on the cycle after the stop sample, i.e. at mid-stop. This tolerates up to a half bit of clock mismatch.
- Framing-error frames: the word is still delivered. If rx_s stays low after the stop sample (break), IDLE starts a new frame, which normally fails framing again.
- Output register and handshake:
  - On completion with out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load out_data and both error flags; out_valid=1 on the next cycle.
  - On completion with out_valid=1 and out_ready=0: drop the new word, keep the held word unchanged, pulse overrun_error for one cycle.
  - Transfer occurs when out_valid and out_ready are both high. out_valid clears on the next cycle unless a new word loads in that same cycle.
  - out_data and flags are stable while out_valid=1 and out_ready=0.
- rx_en low: aborts any frame in progress (back to IDLE, no output). The output register and out_valid are unaffected.
- flush_rx: next cycle state=IDLE, out_valid=0, flags=0, tick counter=0. It takes priority over completion in the same cycle, so no overrun pulse is generated.
- Parity arithmetic: reduction XOR over DATA_BITS bits only; the parity flag is 0 when parity_en=0.

Optional Feature:
- Macro: UART_RX_RTS_EN.
- Defined: adds input flow_control (1) and output rts_n (1). The output register reset value is 1.
  - rts_n=1 (stop sender) when flow_control=1 and out_valid=1, i.e. one word is buffered and unaccepted.
  - rts_n=0 otherwise. rts_n is registered (one-cycle latency).
  - Reception continues while rts_n=1; overrun rules are unchanged.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- divider=0, no parity, rx frame 0xA5 (16 clk/bit), out_ready=1: out_valid pulses once with out_data=0xA5 and both error flags 0; it asserts about 152 cycles after the start edge (~9.5 bits plus synchronizer/register latency).
- parity_en=1, parity_odd=0, send 0x03 with parity bit 1 (wrong for even): out_data=0x03 with out_parity_err=1. The same frame with parity bit 0 gives out_parity_err=0.
- Stop bit driven 0 for frame 0x5A: out_data=0x5A, out_framing_err=1; the next normal frame 0x11 is received cleanly.
- out_ready=0, send two frames 0x01 then 0x02: out_data stays 0x01, overrun_error pulses exactly one cycle at completion of 0x02. Raising out_ready delivers 0x01 only.
- 4-clock low glitch on rx (divider=0, < half bit): no out_valid, busy returns to 0 after the mid-start sample.
- Assert rst, and separately flush_rx, mid-DATA of frame 0xFF: all outputs 0 and state IDLE, no output from the aborted frame; the following frame 0x3C is received correctly.
